// File: rtl/fe_mem_responder.sv
// fe_mem_responder: memory-backed responder for the native front-end request interface.
// Latency: cpu_ready in cycle 1+LATENCY after the request is sampled; cpu_rvalid and cpu_rdata one cycle later.
// Backpressure: accepts one request at a time, and cpu_valid is ignored outside IDLE (including the TURN cycle).
//
// Ports:
//   clk, reset              - clock and synchronous active-high reset
//   cpu_valid/addr/wdata/wstrb - request; wstrb != 0 is a write, wstrb == 0 is a read
//   cpu_ready               - one-cycle completion strobe per request
//   cpu_rvalid, cpu_rdata   - read response; rdata holds until the next read response
//   addr_err                - pulses with cpu_ready when the address is beyond the implemented depth
//   wr_count, rd_count      - saturating completed-access counters
module fe_mem_responder #(
    parameter int FE_ADDR_W = 19,
    parameter int FE_DATA_W = 256,
    parameter int FE_STRB_W = FE_DATA_W / 8,
    parameter int MEM_AW    = 10,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_valid,
    input  logic [FE_ADDR_W-1:0] cpu_addr,
    input  logic [FE_DATA_W-1:0] cpu_wdata,
    input  logic [FE_STRB_W-1:0] cpu_wstrb,
    output logic                 cpu_ready,
    output logic                 cpu_rvalid,
    output logic [FE_DATA_W-1:0] cpu_rdata,
    output logic                 addr_err,
    output logic [15:0]          wr_count,
    output logic [15:0]          rd_count
);

    localparam int          DEPTH = 2 ** MEM_AW;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;

    // Request copies taken in IDLE; everything after capture works from these.
    logic [MEM_AW-1:0]      addr_q;
    logic [FE_DATA_W-1:0]   wdata_q;
    logic [FE_STRB_W-1:0]   wstrb_q;
    logic                   is_wr_q;
    logic                   err_q;

    logic [FE_DATA_W-1:0]   rdata_q;
    logic [15:0]            wr_cnt_q;
    logic [15:0]            rd_cnt_q;

    logic [FE_DATA_W-1:0]   mem [DEPTH];

    logic                   out_of_range;
    logic                   capture;
    logic                   in_ack;
    logic                   mem_we;

    // Anything set above the implemented address bits is out of range.
    generate
        if (FE_ADDR_W > MEM_AW) begin : g_range
            assign out_of_range = |cpu_addr[FE_ADDR_W-1:MEM_AW];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign capture = (state_q == IDLE) && cpu_valid;
    assign in_ack  = (state_q == ACK);
    // Reset wins over a write whose ACK cycle coincides with it.
    assign mem_we  = in_ack && is_wr_q && !err_q && !reset;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_valid) begin
                    cnt_d   = LAT;
                    state_d = (LAT == 4'd0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                // Counter starts at LATENCY, so WAIT lasts exactly LATENCY cycles.
                if (cnt_q <= 4'd1) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK:  state_d = TURN;
            // cpu_valid may still be high from the initiator's late deassert; never sample it here.
            TURN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rdata_q  <= '0;
            wr_cnt_q <= 16'd0;
            rd_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (in_ack) begin
                if (is_wr_q) begin
                    if (wr_cnt_q != 16'hFFFF) begin
                        wr_cnt_q <= wr_cnt_q + 16'd1;
                    end
                end else begin
                    rdata_q <= err_q ? '0 : mem[addr_q];
                    if (rd_cnt_q != 16'hFFFF) begin
                        rd_cnt_q <= rd_cnt_q + 16'd1;
                    end
                end
            end
        end
    end

    // Capture registers carry no reset: they are only consumed after a fresh capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q  <= cpu_addr[MEM_AW-1:0];
            wdata_q <= cpu_wdata;
            wstrb_q <= cpu_wstrb;
            is_wr_q <= |cpu_wstrb;
            err_q   <= out_of_range;
        end
    end

    // Storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < FE_STRB_W; i++) begin
                if (wstrb_q[i]) begin
                    mem[addr_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
                end
            end
        end
    end

    assign cpu_ready  = in_ack;
    assign addr_err   = in_ack && err_q;
    assign cpu_rvalid = (state_q == TURN) && !is_wr_q;
    assign cpu_rdata  = rdata_q;
    assign wr_count   = wr_cnt_q;
    assign rd_count   = rd_cnt_q;

endmodule

// File: tb/tb_fe_mem_responder.sv
// Directed bench for fe_mem_responder at LATENCY 2, 0 and 15.
// Each access runs a fixed observation window and records ready/rvalid timing, read data and addr_err.
// Expected values are hand-computed constants built in the initial block.
module tb_fe_mem_responder;

    logic         clk;
    logic         reset;
    logic         v0, v2, v15;
    logic [18:0]  addr;
    logic [255:0] wdata;
    logic [31:0]  wstrb;

    logic         rdy0, rdy2, rdy15;
    logic         rv0, rv2, rv15;
    logic [255:0] rd0, rd2, rd15;
    logic         er0, er2, er15;
    logic [15:0]  wc0, wc2, wc15;
    logic [15:0]  rc0, rc2, rc15;

    int checks = 0;
    int errors = 0;

    // Results of the most recent access
    int           r_rdy_n, r_rdy_cyc, r_rv_n, r_rv_cyc;
    logic [255:0] r_rdata;
    logic         r_err;

    fe_mem_responder #(.LATENCY(2)) u2 (
        .clk(clk), .reset(reset), .cpu_valid(v2), .cpu_addr(addr), .cpu_wdata(wdata),
        .cpu_wstrb(wstrb), .cpu_ready(rdy2), .cpu_rvalid(rv2), .cpu_rdata(rd2),
        .addr_err(er2), .wr_count(wc2), .rd_count(rc2)
    );

    fe_mem_responder #(.LATENCY(0)) u0 (
        .clk(clk), .reset(reset), .cpu_valid(v0), .cpu_addr(addr), .cpu_wdata(wdata),
        .cpu_wstrb(wstrb), .cpu_ready(rdy0), .cpu_rvalid(rv0), .cpu_rdata(rd0),
        .addr_err(er0), .wr_count(wc0), .rd_count(rc0)
    );

    fe_mem_responder #(.LATENCY(15)) u15 (
        .clk(clk), .reset(reset), .cpu_valid(v15), .cpu_addr(addr), .cpu_wdata(wdata),
        .cpu_wstrb(wstrb), .cpu_ready(rdy15), .cpu_rvalid(rv15), .cpu_rdata(rd15),
        .addr_err(er15), .wr_count(wc15), .rd_count(rc15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input int lat, input logic val);
        case (lat)
            0:       v0  = val;
            15:      v15 = val;
            default: v2  = val;
        endcase
    endtask

    // One request to the instance with the given LATENCY. Inputs are scrambled after
    // the capture edge; with late=1 cpu_valid is held through the TURN cycle.
    task automatic access(input int lat, input logic [18:0] a, input logic [255:0] d,
                          input logic [31:0] s, input bit late);
        logic         rdy, rv, er;
        logic [255:0] rd;
        r_rdy_n = 0; r_rdy_cyc = -1; r_rv_n = 0; r_rv_cyc = -1;
        r_rdata = '0; r_err = 1'b0;
        addr = a; wdata = d; wstrb = s;
        set_valid(lat, 1'b1);
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                addr = a ^ 19'h1; wdata = ~d; wstrb = ~s;
            end
            case (lat)
                0:       begin rdy = rdy0;  rv = rv0;  rd = rd0;  er = er0;  end
                15:      begin rdy = rdy15; rv = rv15; rd = rd15; er = er15; end
                default: begin rdy = rdy2;  rv = rv2;  rd = rd2;  er = er2;  end
            endcase
            if (rdy) begin
                r_rdy_n++;
                if (r_rdy_cyc < 0) begin
                    r_rdy_cyc = c;
                    r_err = er;
                end
            end
            if (rv) begin
                r_rv_n++;
                if (r_rv_cyc < 0) begin
                    r_rv_cyc = c;
                    r_rdata = rd;
                end
            end
            if (r_rdy_cyc >= 0 && c == r_rdy_cyc + (late ? 2 : 0)) set_valid(lat, 1'b0);
        end
        set_valid(lat, 1'b0);
    endtask

    initial begin
        logic [255:0] w0, w1, all_aa, all_55, merged, pa, pb, ones, w_l0, w_l15;
        int           aborted_rdy;

        for (int i = 0; i < 8; i++) begin
            w0[i*32 +: 32] = 32'(i);
            w1[i*32 +: 32] = 32'(i + 8);
        end
        all_aa = {32{8'hAA}};
        all_55 = {32{8'h55}};
        merged = {{28{8'hAA}}, {4{8'h55}}};
        ones   = {256{1'b1}};
        pa     = {8{32'hCAFE_0003}};
        pb     = {8{32'hDEAD_BEEF}};
        w_l0   = {8{32'h1234_5678}};
        w_l15  = {8{32'h9ABC_DEF0}};

        reset = 1'b1; v0 = 1'b0; v2 = 1'b0; v15 = 1'b0;
        addr = '0; wdata = '0; wstrb = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        check("rst_ready",  256'(rdy2), 256'(0));
        check("rst_rvalid", 256'(rv2),  256'(0));
        check("rst_rdata",  rd2,        256'(0));
        check("rst_err",    256'(er2),  256'(0));
        check("rst_wrcnt",  256'(wc2),  256'(0));
        check("rst_rdcnt",  256'(rc2),  256'(0));

        // Basic write/read, LATENCY=2
        access(2, 19'd0, w0, 32'hFFFF_FFFF, 1'b0);
        check("wr0_rdy_cyc", 256'(r_rdy_cyc), 256'(3));
        check("wr0_rdy_n",   256'(r_rdy_n),   256'(1));
        check("wr0_rv_n",    256'(r_rv_n),    256'(0));
        access(2, 19'd1, w1, 32'hFFFF_FFFF, 1'b0);
        access(2, 19'd1, '0, 32'h0, 1'b0);
        check("rd1_rdy_cyc", 256'(r_rdy_cyc), 256'(3));
        check("rd1_rv_cyc",  256'(r_rv_cyc),  256'(4));
        check("rd1_rv_n",    256'(r_rv_n),    256'(1));
        check("rd1_data",    r_rdata,         w1);
        access(2, 19'd0, '0, 32'h0, 1'b0);
        check("rd0_data",    r_rdata,         w0);
        check("basic_wrcnt", 256'(wc2), 256'(2));
        check("basic_rdcnt", 256'(rc2), 256'(2));

        // Partial strobe merge
        access(2, 19'd5, all_aa, 32'hFFFF_FFFF, 1'b0);
        access(2, 19'd5, all_55, 32'h0000_000F, 1'b0);
        access(2, 19'd5, '0, 32'h0, 1'b0);
        check("partial_data", r_rdata, merged);

        // Late deassert: valid held through TURN
        access(2, 19'd6, w1, 32'hFFFF_FFFF, 1'b1);
        check("late_rdy_n",  256'(r_rdy_n), 256'(1));
        check("late_wrcnt",  256'(wc2),     256'(5));
        check("rdata_hold",  rd2,           merged);

        // Out of range
        access(2, 19'h400, ones, 32'hFFFF_FFFF, 1'b0);
        check("oor_wr_err",  256'(r_err), 256'(1));
        check("oor_wr_rdy",  256'(r_rdy_n), 256'(1));
        access(2, 19'h400, '0, 32'h0, 1'b0);
        check("oor_rd_err",  256'(r_err), 256'(1));
        check("oor_rd_data", r_rdata, 256'(0));
        access(2, 19'd0, '0, 32'h0, 1'b0);
        check("oor_a0_err",  256'(r_err), 256'(0));
        check("oor_a0_data", r_rdata, w0);
        check("oor_wrcnt",   256'(wc2), 256'(6));
        check("oor_rdcnt",   256'(rc2), 256'(5));

        // Latency sweep
        access(0, 19'd2, w_l0, 32'hFFFF_FFFF, 1'b0);
        check("l0_wr_rdy_cyc", 256'(r_rdy_cyc), 256'(1));
        access(0, 19'd2, '0, 32'h0, 1'b0);
        check("l0_rd_rdy_cyc", 256'(r_rdy_cyc), 256'(1));
        check("l0_rd_rv_cyc",  256'(r_rv_cyc),  256'(2));
        check("l0_rd_data",    r_rdata,         w_l0);
        access(15, 19'd2, w_l15, 32'hFFFF_FFFF, 1'b0);
        check("l15_wr_rdy_cyc", 256'(r_rdy_cyc), 256'(16));
        access(15, 19'd2, '0, 32'h0, 1'b0);
        check("l15_rd_rdy_cyc", 256'(r_rdy_cyc), 256'(16));
        check("l15_rd_rv_cyc",  256'(r_rv_cyc),  256'(17));
        check("l15_rd_data",    r_rdata,         w_l15);

        // Reset during WAIT of a write to addr 3
        access(2, 19'd3, pa, 32'hFFFF_FFFF, 1'b0);
        aborted_rdy = 0;
        addr = 19'd3; wdata = pb; wstrb = 32'hFFFF_FFFF; v2 = 1'b1;
        @(posedge clk); #1;
        if (rdy2) aborted_rdy++;
        reset = 1'b1; v2 = 1'b0;
        @(posedge clk); #1;
        if (rdy2) aborted_rdy++;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (rdy2) aborted_rdy++;
        end
        check("abort_rdy_n",  256'(aborted_rdy), 256'(0));
        check("abort_wrcnt",  256'(wc2), 256'(0));
        check("abort_rdcnt",  256'(rc2), 256'(0));
        check("abort_rdata",  rd2,       256'(0));
        access(2, 19'd3, '0, 32'h0, 1'b0);
        check("abort_rd_data", r_rdata, pa);
        check("abort_rd_cnt",  256'(rc2), 256'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
